// File: rtl/hazard_sb.sv
// Hazard scoreboard: tracks in-flight destination registers after decode and
// derives forwarding selects, load-use stall and branch flush. Optional HAZARD_PERF_EN adds stall/flush cycle counters.
module hazard_sb #(
    parameter  int NSTAGE     = 2,
    parameter  int LOAD_STAGE = 2,
    parameter  int RW         = 5,
    localparam int SW         = $clog2(NSTAGE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [RW-1:0] id_rd,
    input  logic          id_regwr,
    input  logic          id_is_load,
    input  logic          br_taken,
    output logic          stall,
    output logic          flush,
    output logic [SW-1:0] fwd_a,
    output logic [SW-1:0] fwd_b
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_cycles
`endif
);

    logic          r_valid   [1:NSTAGE];
    logic [RW-1:0] r_rd      [1:NSTAGE];
    logic          r_regwr   [1:NSTAGE];
    logic          r_is_load [1:NSTAGE];

    logic          w_match_a [1:NSTAGE];
    logic          w_match_b [1:NSTAGE];
    logic [SW-1:0] w_fwd_a;
    logic [SW-1:0] w_fwd_b;
    logic          w_load_use;
    logic          w_issue;

    // x0 producers never match, so they can shift through harmlessly
    for (genvar k = 1; k <= NSTAGE; k++) begin : g_match
        assign w_match_a[k] = r_valid[k] && r_regwr[k] && (r_rd[k] != '0)
                              && (r_rd[k] == id_rs1) && id_use_rs1;
        assign w_match_b[k] = r_valid[k] && r_regwr[k] && (r_rd[k] != '0)
                              && (r_rd[k] == id_rs2) && id_use_rs2;
    end

    // Scan oldest to youngest so the youngest producer overwrites the select
    always_comb begin
        w_fwd_a    = '0;
        w_fwd_b    = '0;
        w_load_use = 1'b0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (w_match_a[k]) w_fwd_a = SW'(k);
            if (w_match_b[k]) w_fwd_b = SW'(k);
            if ((w_match_a[k] || w_match_b[k]) && r_is_load[k] && (k < LOAD_STAGE))
                w_load_use = 1'b1;
        end
    end

    assign stall   = id_valid & w_load_use & ~br_taken;
    assign flush   = br_taken;
    assign fwd_a   = stall ? '0 : w_fwd_a;
    assign fwd_b   = stall ? '0 : w_fwd_b;
    assign w_issue = id_valid & ~stall & ~br_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                r_valid[k]   <= 1'b0;
                r_rd[k]      <= '0;
                r_regwr[k]   <= 1'b0;
                r_is_load[k] <= 1'b0;
            end
        end else begin
            for (int k = NSTAGE; k >= 2; k--) begin
                r_valid[k]   <= r_valid[k-1];
                r_rd[k]      <= r_rd[k-1];
                r_regwr[k]   <= r_regwr[k-1];
                r_is_load[k] <= r_is_load[k-1];
            end
            r_valid[1]   <= w_issue;
            r_rd[1]      <= id_rd;
            r_regwr[1]   <= id_regwr;
            r_is_load[1] <= id_is_load;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (stall) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush) r_flush_cycles <= r_flush_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Testbench for hazard_sb: directed scenarios plus random traffic checked
// against a queue-based pipeline model through an expected-response scoreboard.
module tb_hazard_sb;

    localparam int NS = 2;
    localparam int LS = 2;
    localparam int RW = 5;
    localparam int SW = $clog2(NS + 1);
    localparam int W  = 2 + 2 * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic [RW-1:0] id_rd;
    logic          id_regwr;
    logic          id_is_load;
    logic          br_taken;
    logic          stall;
    logic          flush;
    logic [SW-1:0] fwd_a;
    logic [SW-1:0] fwd_b;
`ifdef HAZARD_PERF_EN
    logic [31:0]   stall_cycles;
    logic [31:0]   flush_cycles;
`endif

    hazard_sb #(.NSTAGE(NS), .LOAD_STAGE(LS), .RW(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_regwr   (id_regwr),
        .id_is_load (id_is_load),
        .br_taken   (br_taken),
        .stall      (stall),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_cycles (flush_cycles)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: pipe[0] is stage 1, pipe[NS-1] is the last stage
    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          wr;
        logic          ld;
    } ent_t;

    ent_t          pipe[$];
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_nm_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            m_stall_cnt = 0;
    int            m_flush_cnt = 0;
    string         name_q[$];

    task automatic model_clear();
        pipe.delete();
        for (int i = 0; i < NS; i++) pipe.push_back('0);
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // drive one decode cycle, push its expected outputs, advance the model
    task automatic drive(input string nm, input bit vld, input int rs1, input int rs2,
                         input bit u1, input bit u2, input int rd, input bit wr,
                         input bit ld, input bit br);
        int fa, fb;
        bit lu, st;
        ent_t e;
        @(posedge clk);
        #1;
        id_valid = vld; id_rs1 = RW'(rs1); id_rs2 = RW'(rs2);
        id_use_rs1 = u1; id_use_rs2 = u2; id_rd = RW'(rd);
        id_regwr = wr; id_is_load = ld; br_taken = br;
        fa = 0; fb = 0; lu = 0;
        for (int k = 1; k <= NS; k++) begin
            e = pipe[k-1];
            if (e.v && e.wr && e.rd != 0) begin
                if (u1 && e.rd == RW'(rs1)) begin
                    if (fa == 0) fa = k;
                    if (e.ld && k < LS) lu = 1;
                end
                if (u2 && e.rd == RW'(rs2)) begin
                    if (fb == 0) fb = k;
                    if (e.ld && k < LS) lu = 1;
                end
            end
        end
        st = vld && lu && !br;
        if (st) begin fa = 0; fb = 0; end
        exp_q.push_back({st, br, SW'(fa), SW'(fb)});
        name_q.push_back(nm);
        if (st) m_stall_cnt++;
        if (br) m_flush_cnt++;
        e.v = vld && !st && !br; e.rd = RW'(rd); e.wr = wr; e.ld = ld;
        pipe.push_front(e);
        void'(pipe.pop_back());
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = '0; id_regwr = 0; id_is_load = 0; br_taken = 0;
    endtask

    // monitor: outputs are combinational, compared mid-cycle
    always @(negedge clk) begin
        logic [W-1:0] exp;
        string nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            n_checks++;
            if ({stall, flush, fwd_a, fwd_b} !== exp) begin
                n_fail++;
                $display("FAIL %s: got stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d, want stall=%0b flush=%0b fwd_a=%0d fwd_b=%0d",
                         nm, stall, flush, fwd_a, fwd_b, exp[W-1], exp[W-2],
                         exp[2*SW-1:SW], exp[SW-1:0]);
            end
        end
    end

    initial begin
        rst = 0;
        idle_inputs();
        br_taken = 1;
        model_clear();
        #2;
        chk("reset_stall", 32'(stall), 0);
        chk("reset_flush", 32'(flush), 1);
        chk("reset_fwd", 32'({fwd_a, fwd_b}), 0);
`ifdef HAZARD_PERF_EN
        chk("reset_ctr", stall_cycles | flush_cycles, 0);
`endif
        @(negedge clk);
        br_taken = 0;
        rst = 1;

        // back-to-back ALU dependency
        drive("alu_prod",   1, 0, 0, 0, 0, 5, 1, 0, 0);
        drive("alu_fwd1",   1, 5, 0, 1, 0, 6, 1, 0, 0);
        drive("alu_fwd2",   1, 5, 0, 1, 0, 0, 0, 0, 0);
        // load-use: one stall cycle, then forwarded from the load stage
        drive("lw_prod",    1, 0, 0, 0, 0, 7, 1, 1, 0);
        drive("lu_stall",   1, 0, 7, 0, 1, 8, 1, 0, 0);
        drive("lu_release", 1, 0, 7, 0, 1, 8, 1, 0, 0);
        // multiple producers of the same register
        drive("mp_old",     1, 0, 0, 0, 0, 3, 1, 0, 0);
        drive("mp_young",   1, 0, 0, 0, 0, 3, 1, 0, 0);
        drive("mp_read",    1, 3, 0, 1, 0, 0, 0, 0, 0);
        // x0 and unused operand
        drive("x0_prod",    1, 0, 0, 0, 0, 0, 1, 0, 0);
        drive("x0_read",    1, 0, 0, 1, 0, 9, 1, 0, 0);
        drive("nouse_read", 1, 0, 9, 0, 0, 0, 0, 0, 0);
        // branch during load-use
        drive("br_lw",      1, 0, 0, 0, 0, 4, 1, 1, 0);
        drive("br_lu",      1, 4, 0, 1, 0, 0, 0, 0, 1);
        drive("br_after",   1, 4, 0, 1, 0, 0, 0, 0, 0);

        // reset mid-flight with two tracked loads
        drive("rs_lw10",    1, 0, 0, 0, 0, 10, 1, 1, 0);
        drive("rs_lw11",    1, 0, 0, 0, 0, 11, 1, 1, 0);
        drive("rs_stall",   1, 11, 10, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        chk("rst_async_stall", 32'(stall), 0);
        chk("rst_async_fwd", 32'({fwd_a, fwd_b}), 0);
        model_clear();
        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        chk("rst_ctr_stall", stall_cycles, 0);
        chk("rst_ctr_flush", flush_cycles, 0);
`endif
        idle_inputs();
        rst = 1;
        drive("post_rst",   1, 11, 10, 1, 1, 0, 0, 0, 0);

        // random traffic over a small register set to provoke hazards
        for (int i = 0; i < 400; i++) begin
            drive("rand", $urandom_range(0, 9) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 7) == 0);
        end

        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_EN
        chk("ctr_stall", stall_cycles, 32'(m_stall_cnt));
        chk("ctr_flush", flush_cycles, 32'(m_flush_cnt));
`endif
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
